exec_cc_mreg: RTL and testbench

- Back end of the execute stage in the Y86-64 PIPE datapath; sits directly downstream of the 64-bit ALU.
- Latches the ALU flag vector into the condition-code (CC) register, gated by instruction type and pipeline exceptions.
- Evaluates the jXX/cmovXX condition and registers all execute results into the E→M pipeline register, with stall and bubble control.

---
 rtl/y86_pkg.sv | 55 +++++
 rtl/exec_cc_mreg_cond_eval.sv | 35 +++
 rtl/exec_cc_mreg.sv | 117 +++++++++++
 tb/tb_exec_cc_mreg.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, condition ifuns, stat codes, register ids,
// and condition-code bit positions used by the PIPE datapath.
package y86_pkg;

   typedef enum logic [3:0] {
      HALT   = 4'h0,
      NOP    = 4'h1,
      RRMOVQ = 4'h2,
      IRMOVQ = 4'h3,
      RMMOVQ = 4'h4,
      MRMOVQ = 4'h5,
      OPQ    = 4'h6,
      JXX    = 4'h7,
      CALL   = 4'h8,
      RET    = 4'h9,
      PUSHQ  = 4'hA,
      POPQ   = 4'hB
   } icode_t;

   typedef enum logic [3:0] {
      C_ALWAYS = 4'h0,
      C_LE     = 4'h1,
      C_L      = 4'h2,
      C_E      = 4'h3,
      C_NE     = 4'h4,
      C_GE     = 4'h5,
      C_G      = 4'h6
   } cond_t;

   typedef enum logic [1:0] {
      AOK = 2'd0,
      HLT = 2'd1,
      ADR = 2'd2,
      INS = 2'd3
   } stat_t;

   typedef enum logic {
      RUN    = 1'b0,
      FROZEN = 1'b1
   } cc_state_t;

   localparam logic [3:0] RNONE = 4'hF;

   localparam int CC_OF = 0;
   localparam int CC_ZF = 1;
   localparam int CC_SF = 2;

   // ZF set, SF/OF clear: the machine starts as if the last result was zero
   localparam logic [2:0] CC_RESET = 3'b010;

   function automatic logic is_cond_insn(input logic [3:0] icode);
      return (icode == JXX) || (icode == RRMOVQ);
   endfunction

endpackage

// File: rtl/exec_cc_mreg_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from a CC vector and ifun.
// Shared with the fetch-stage branch predictor checker.
module cond_eval
   import y86_pkg::*;
(
   input  logic [2:0] cc,
   input  logic [3:0] ifun,
   output logic       cnd
);

   logic sf;
   logic zf;
   logic of;
   logic lt;

   assign sf = cc[CC_SF];
   assign zf = cc[CC_ZF];
   assign of = cc[CC_OF];
   assign lt = sf ^ of;

   always_comb begin
      cnd = 1'b0;
      case (ifun)
         C_ALWAYS: cnd = 1'b1;
         C_LE:     cnd = lt | zf;
         C_L:      cnd = lt;
         C_E:      cnd = zf;
         C_NE:     cnd = ~zf;
         C_GE:     cnd = ~lt;
         C_G:      cnd = ~lt & ~zf;
         default:  cnd = 1'b0;
      endcase
   end

endmodule

// File: rtl/exec_cc_mreg.sv
// Y86-64 PIPE execute back end: CC register with exception freeze, condition
// evaluation, cmov dstE squash and the E->M pipeline register.
// Optional branch/cmov outcome counters under `EXEC_PERF_CNT_EN.
module exec_cc_mreg
   import y86_pkg::*;
#(
   parameter int N = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    e_stat,
   input  logic [3:0]    e_icode,
   input  logic [3:0]    e_ifun,
   input  logic [N-1:0]  e_valE,
   input  logic [2:0]    e_flags,
   input  logic [N-1:0]  e_valA,
   input  logic [3:0]    e_dstE,
   input  logic [3:0]    e_dstM,
   input  logic          m_exc,
   input  logic          w_exc,
   input  logic          M_stall,
   input  logic          M_bubble,
   output logic          e_Cnd,
   output logic [2:0]    cc_q,
   output logic [1:0]    M_stat,
   output logic [3:0]    M_icode,
   output logic          M_Cnd,
   output logic [N-1:0]  M_valE,
   output logic [N-1:0]  M_valA,
   output logic [3:0]    M_dstE,
   output logic [3:0]    M_dstM
`ifdef EXEC_PERF_CNT_EN
   ,
   output logic [31:0]   cnt_taken,
   output logic [31:0]   cnt_not_taken
`endif
);

   cc_state_t  state;
   logic       set_cc;
   logic       m_load;
   logic [3:0] dstE_sq;

   // Condition comes from the committed CC, so an OPq directly ahead is already visible
   cond_eval u_cond_eval (
      .cc   (cc_q),
      .ifun (e_ifun),
      .cnd  (e_Cnd)
   );

   assign m_load = ~M_bubble & ~M_stall;

   assign set_cc = (e_icode == OPQ) & ~m_exc & ~w_exc &
                   (state == RUN) & (e_stat == AOK);

   assign dstE_sq = ((e_icode == RRMOVQ) && !e_Cnd) ? RNONE : e_dstE;

   // Flag-update FSM: once a faulting instruction enters M, CC never changes again
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cc_q  <= CC_RESET;
      end else begin
         if (set_cc)
            cc_q <= e_flags;
         case (state)
            RUN:     if (m_load && (e_stat != AOK)) state <= FROZEN;
            FROZEN:  state <= FROZEN;
            default: state <= RUN;
         endcase
      end
   end

   // E->M register: bubble beats stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         M_stat  <= AOK;
         M_icode <= NOP;
         M_Cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= RNONE;
         M_dstM  <= RNONE;
      end else if (M_bubble) begin
         M_stat  <= AOK;
         M_icode <= NOP;
         M_Cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= RNONE;
         M_dstM  <= RNONE;
      end else if (!M_stall) begin
         M_stat  <= e_stat;
         M_icode <= e_icode;
         M_Cnd   <= e_Cnd;
         M_valE  <= e_valE;
         M_valA  <= e_valA;
         M_dstE  <= dstE_sq;
         M_dstM  <= e_dstM;
      end
   end

`ifdef EXEC_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_taken     <= '0;
         cnt_not_taken <= '0;
      end else if (m_load && is_cond_insn(e_icode)) begin
         if (e_Cnd)
            cnt_taken     <= cnt_taken + 32'd1;
         else
            cnt_not_taken <= cnt_not_taken + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_exec_cc_mreg.sv
// Scoreboard bench for exec_cc_mreg: a behavioural model queues the expected
// M register contents each cycle and they are compared after the clock edge.
module tb_exec_cc_mreg;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  e_stat;
   logic [3:0]  e_icode;
   logic [3:0]  e_ifun;
   logic [63:0] e_valE;
   logic [2:0]  e_flags;
   logic [63:0] e_valA;
   logic [3:0]  e_dstE;
   logic [3:0]  e_dstM;
   logic        m_exc;
   logic        w_exc;
   logic        M_stall;
   logic        M_bubble;
   logic        e_Cnd;
   logic [2:0]  cc_q;
   logic [1:0]  M_stat;
   logic [3:0]  M_icode;
   logic        M_Cnd;
   logic [63:0] M_valE;
   logic [63:0] M_valA;
   logic [3:0]  M_dstE;
   logic [3:0]  M_dstM;
`ifdef EXEC_PERF_CNT_EN
   logic [31:0] cnt_taken;
   logic [31:0] cnt_not_taken;
`endif

   exec_cc_mreg #(.N(64)) dut (
      .clk      (clk),
      .rst      (rst),
      .e_stat   (e_stat),
      .e_icode  (e_icode),
      .e_ifun   (e_ifun),
      .e_valE   (e_valE),
      .e_flags  (e_flags),
      .e_valA   (e_valA),
      .e_dstE   (e_dstE),
      .e_dstM   (e_dstM),
      .m_exc    (m_exc),
      .w_exc    (w_exc),
      .M_stall  (M_stall),
      .M_bubble (M_bubble),
      .e_Cnd    (e_Cnd),
      .cc_q     (cc_q),
      .M_stat   (M_stat),
      .M_icode  (M_icode),
      .M_Cnd    (M_Cnd),
      .M_valE   (M_valE),
      .M_valA   (M_valA),
      .M_dstE   (M_dstE),
      .M_dstM   (M_dstM)
`ifdef EXEC_PERF_CNT_EN
      ,
      .cnt_taken     (cnt_taken),
      .cnt_not_taken (cnt_not_taken)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  stat;
      logic [3:0]  icode;
      logic        cnd;
      logic [63:0] valE;
      logic [63:0] valA;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
   } mrec_t;

   int          total = 0;
   int          bad   = 0;
   mrec_t       sb[$];
   mrec_t       m_cur;
   mrec_t       nop_rec;
   logic [2:0]  m_cc;
   logic        m_frozen;
   logic [31:0] m_taken;
   logic [31:0] m_not_taken;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic model_cnd(input logic [2:0] c, input logic [3:0] f);
      logic sf, zf, of;
      sf = c[2]; zf = c[1]; of = c[0];
      case (f)
         4'd0:    return 1'b1;
         4'd1:    return (sf ^ of) | zf;
         4'd2:    return sf ^ of;
         4'd3:    return zf;
         4'd4:    return !zf;
         4'd5:    return !(sf ^ of);
         4'd6:    return !(sf ^ of) && !zf;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_cc        = 3'b010;
      m_frozen    = 1'b0;
      m_cur       = nop_rec;
      m_taken     = '0;
      m_not_taken = '0;
      sb.delete();
   endtask

   task automatic check_m(input string tag, input mrec_t e);
      chk({tag, ".stat"},  {62'd0, M_stat},  {62'd0, e.stat});
      chk({tag, ".icode"}, {60'd0, M_icode}, {60'd0, e.icode});
      chk({tag, ".cnd"},   {63'd0, M_Cnd},   {63'd0, e.cnd});
      chk({tag, ".valE"},  M_valE,           e.valE);
      chk({tag, ".valA"},  M_valA,           e.valA);
      chk({tag, ".dstE"},  {60'd0, M_dstE},  {60'd0, e.dstE});
      chk({tag, ".dstM"},  {60'd0, M_dstM},  {60'd0, e.dstM});
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".cc"}, {61'd0, cc_q}, 64'd2);
      check_m(tag, nop_rec);
   endtask

   // Drive one E-stage instruction just after a rising edge, check e_Cnd mid-cycle,
   // queue the expected M contents, then compare after the next edge.
   task automatic step(input string tag, input logic [1:0] st, input logic [3:0] ic,
                       input logic [3:0] fn, input logic [63:0] ve, input logic [2:0] fl,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                       input logic mx, input logic wx, input logic stl, input logic bub);
      mrec_t      nxt;
      logic       cnd;
      logic [2:0] ncc;
      e_stat = st; e_icode = ic; e_ifun = fn; e_valE = ve; e_flags = fl;
      e_valA = va; e_dstE = de; e_dstM = dm; m_exc = mx; w_exc = wx;
      M_stall = stl; M_bubble = bub;
      cnd = model_cnd(m_cc, fn);
      #3;
      chk({tag, ".eCnd"}, {63'd0, e_Cnd}, {63'd0, cnd});
      if (bub) nxt = nop_rec;
      else if (stl) nxt = m_cur;
      else begin
         nxt.stat = st; nxt.icode = ic; nxt.cnd = cnd; nxt.valE = ve; nxt.valA = va;
         nxt.dstE = (ic == 4'h2 && !cnd) ? 4'hF : de;
         nxt.dstM = dm;
      end
      sb.push_back(nxt);
      ncc = (ic == 4'h6 && !mx && !wx && !m_frozen && st == 2'd0) ? fl : m_cc;
      if (!bub && !stl) begin
         if (st != 2'd0) m_frozen = 1'b1;
         if (ic == 4'h7 || ic == 4'h2) begin
            if (cnd) m_taken++;
            else m_not_taken++;
         end
      end
      @(posedge clk);
      #1;
      m_cc  = ncc;
      m_cur = sb.pop_front();
      chk({tag, ".cc"}, {61'd0, cc_q}, {61'd0, m_cc});
      check_m(tag, m_cur);
   endtask

   task automatic opq(input string tag, input logic [2:0] fl);
      step(tag, 2'd0, 4'h6, 4'h0, 64'h1234, fl, 64'h55, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic jxx(input string tag, input logic [3:0] fn);
      step(tag, 2'd0, 4'h7, fn, 64'h0, 3'b000, 64'h400, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      nop_rec = '{stat: 2'd0, icode: 4'h1, cnd: 1'b0, valE: 64'd0, valA: 64'd0,
                  dstE: 4'hF, dstM: 4'hF};
      rst = 1'b1;
      e_stat = 2'd0; e_icode = 4'h1; e_ifun = 4'h0; e_valE = '0; e_flags = 3'b000;
      e_valA = '0; e_dstE = 4'hF; e_dstM = 4'hF; m_exc = 1'b0; w_exc = 1'b0;
      M_stall = 1'b0; M_bubble = 1'b0;
      model_reset();
      #12;
      check_reset("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Flags reach jXX the very next cycle
      opq("op000", 3'b000);
      jxx("je_z0", 4'd3);
      opq("op010", 3'b010);
      jxx("je_z1", 4'd3);
      jxx("jne_z1", 4'd4);

      // Signed overflow: 0x7FFF..FF + 1 sets SF and OF
      step("op_ovf", 2'd0, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 3'b101, 64'h1, 4'h3,
           4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
      jxx("jl_ovf", 4'd2);
      jxx("jge_ovf", 4'd5);

      // cmovne squash
      opq("op_z1", 3'b010);
      step("cmov_sq", 2'd0, 4'h2, 4'd4, 64'hAB, 3'b000, 64'hAB, 4'h3, 4'hF,
           1'b0, 1'b0, 1'b0, 1'b0);
      opq("op_z0", 3'b000);
      step("cmov_ok", 2'd0, 4'h2, 4'd4, 64'hCD, 3'b000, 64'hCD, 4'h3, 4'hF,
           1'b0, 1'b0, 1'b0, 1'b0);

      // Full condition table over several CC values
      for (int c = 0; c < 8; c++) begin
         opq("sw_op", c[2:0]);
         for (int f = 0; f < 16; f++) jxx("sw_j", f[3:0]);
      end

      // Stall holds M but not CC; bubble beats stall
      step("stall1", 2'd0, 4'h6, 4'h0, 64'h99, 3'b100, 64'h98, 4'h5, 4'hF,
           1'b0, 1'b0, 1'b1, 1'b0);
      step("stall2", 2'd0, 4'h3, 4'h0, 64'h77, 3'b000, 64'h76, 4'h6, 4'hF,
           1'b0, 1'b0, 1'b1, 1'b0);
      step("stbub", 2'd0, 4'h5, 4'h0, 64'h66, 3'b000, 64'h65, 4'h7, 4'h8,
           1'b0, 1'b0, 1'b1, 1'b1);

      // Exceptions downstream block CC writes
      opq("op_pre", 3'b010);
      step("mexc", 2'd0, 4'h6, 4'h0, 64'h1, 3'b100, 64'h0, 4'h1, 4'hF,
           1'b1, 1'b0, 1'b0, 1'b0);
      step("wexc", 2'd0, 4'h6, 4'h0, 64'h1, 3'b001, 64'h0, 4'h1, 4'hF,
           1'b0, 1'b1, 1'b0, 1'b0);

      // Random traffic with AOK stat
      for (int i = 0; i < 200; i++) begin
         step("rnd", 2'd0, 4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)),
              {$urandom, $urandom}, 3'($urandom), {$urandom, $urandom},
              4'($urandom), 4'($urandom), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 6) == 0));
      end

      // Bubbled or stalled faults do not freeze; a loaded fault does
      step("adr_bub", 2'd2, 4'h5, 4'h0, 64'h10, 3'b000, 64'h0, 4'hF, 4'h3,
           1'b0, 1'b0, 1'b0, 1'b1);
      opq("run_ok", 3'b110);
      step("adr_ld", 2'd2, 4'h5, 4'h0, 64'h10, 3'b000, 64'h0, 4'hF, 4'h3,
           1'b0, 1'b0, 1'b0, 0);
      opq("frz1", 3'b001);
      opq("frz2", 3'b100);

      // Mid-cycle reset clears everything without a clock edge
      step("preld", 2'd1, 4'h0, 4'h0, 64'hDEAD, 3'b000, 64'hBEEF, 4'h2, 4'h4,
           1'b0, 1'b0, 1'b0, 1'b0);
      e_icode = 4'h1; e_stat = 2'd0; M_bubble = 1'b1; M_stall = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_reset("midrst");
      model_reset();
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      opq("post_rst", 3'b101);
      jxx("post_jg", 4'd6);

`ifdef EXEC_PERF_CNT_EN
      chk("cnt_taken", {32'd0, cnt_taken}, {32'd0, m_taken});
      chk("cnt_not_taken", {32'd0, cnt_not_taken}, {32'd0, m_not_taken});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
